// File: rtl/jk_pkg.sv
// jk_pkg: shared constants for the JK-cell counter slice.
//   MODE_*  : counter operating mode, as driven on jk_mod_counter.mode
//   JK_*    : {j,k} control encodings understood by jk_ff_cell
package jk_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // {j,k} pairs
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_CLEAR  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_ff_cell.sv
// jk_ff_cell: one JK storage bit with synchronous active-high reset.
//   clk     : rising-edge clock
//   rst     : synchronous reset, loads rst_val
//   rst_val : value taken on reset
//   j, k    : 00 hold, 01 clear, 10 set, 11 toggle
//   q       : registered bit
module jk_ff_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) q <= rst_val;
    else begin
      case ({j, k})
        JK_SET:    q <= 1'b1;
        JK_CLEAR:  q <= 1'b0;
        JK_TOGGLE: q <= ~q;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MODULUS up/down/load counter built from WIDTH JK cells.
//   clk      : rising-edge clock
//   rst      : synchronous reset, q <= RESET_VAL, wrap <= 0
//   en       : enable; 0 holds state
//   mode     : 00 hold, 01 up, 10 down, 11 load
//   load_val : load data, clamped to MODULUS-1
//   q        : registered count, always in 0..MODULUS-1
//   tc       : combinational terminal count (next enabled edge wraps)
//   wrap     : registered pulse, one cycle per wrap event
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 10,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);

  // One extra bit: the carry/borrow detects the wrap without ever
  // letting an out-of-range value reach q.
  logic [WIDTH:0]   q_ext, inc, dec, ld_ext;
  logic [WIDTH-1:0] nxt, j, k;
  logic             wrap_nxt, is_load;

  assign q_ext  = {1'b0, q};
  assign inc    = q_ext + (WIDTH+1)'(1);
  assign dec    = q_ext - (WIDTH+1)'(1);
  assign ld_ext = {1'b0, load_val};

  always_comb begin
    nxt      = q;
    wrap_nxt = 1'b0;
    is_load  = 1'b0;
    if (en) begin
      case (mode)
        MODE_UP: begin
          // >= also catches a forced out-of-range q: goes to 0 with wrap
          if (inc >= MOD_EXT) begin
            nxt      = '0;
            wrap_nxt = 1'b1;
          end else nxt = inc[WIDTH-1:0];
        end
        MODE_DOWN: begin
          // borrow only from 0; an out-of-range q just decrements
          if (dec[WIDTH]) begin
            nxt      = MAX;
            wrap_nxt = 1'b1;
          end else nxt = dec[WIDTH-1:0];
        end
        MODE_LOAD: begin
          is_load = 1'b1;
          nxt     = (ld_ext < MOD_EXT) ? load_val : MAX;
        end
        default: ;
      endcase
    end
  end

  // Counting toggles exactly the changing bits; load drives set/clear
  // directly from the data; hold leaves j=k=0 since nxt==q.
  assign j = is_load ?  nxt : (q ^ nxt);
  assign k = is_load ? ~nxt : (q ^ nxt);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .rst_val(RST_V[i]),
      .j      (j[i]),
      .k      (k[i]),
      .q      (q[i])
    );
  end

  assign tc = en & (((mode == MODE_UP)   & (q == MAX)) |
                    ((mode == MODE_DOWN) & (q == '0)));

  always_ff @(posedge clk) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= wrap_nxt;
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;

  localparam logic [1:0] HOLD = 2'b00, UP = 2'b01, DN = 2'b10, LD = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] load_val = 4'd0;
  logic [3:0] q;
  logic       tc, wrap;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load_val(load_val),
    .q(q), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       chk_tc;
    logic       tc;
    logic [3:0] q;
    logic       wrap;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;
  int   wraps_seen = 0;

  // Inputs applied at negedge; expectation: tc for those inputs and the
  // current state, q/wrap after the following rising edge.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [3:0] lv, input logic xq, input logic xw,
                      input logic xtc, input logic ctc, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; load_val = lv;
    x.chk_tc = ctc; x.tc = xtc; x.q = xq ? 4'd0 : 4'd0; x.q = 4'd0;
    x.wrap = xw; x.name = nm;
    sb.push_back(x);
  endtask

  // q expectation passed separately to keep the task signature simple
  task automatic stepq(input logic r, input logic e, input logic [1:0] m,
                       input logic [3:0] lv, input logic [3:0] xq,
                       input logic xw, input logic xtc, input logic ctc,
                       input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; load_val = lv;
    x.chk_tc = ctc; x.tc = xtc; x.q = xq; x.wrap = xw; x.name = nm;
    sb.push_back(x);
  endtask

  // Monitor: samples tc after inputs settle, q/wrap after the edge.
  initial begin : monitor
    exp_t e;
    logic tc_s;
    forever begin
      @(negedge clk); #2;
      if (sb.size() != 0) begin
        tc_s = tc;
        @(posedge clk); #1;
        e = sb.pop_front();
        if (wrap === 1'b1) wraps_seen++;
        if (e.chk_tc) begin
          checks++;
          if (tc_s !== e.tc) begin
            errs++;
            $display("FAIL %s tc: got %b want %b", e.name, tc_s, e.tc);
          end
        end
        checks++;
        if (q !== e.q) begin
          errs++;
          $display("FAIL %s q: got %0d want %0d", e.name, q, e.q);
        end
        checks++;
        if (wrap !== e.wrap) begin
          errs++;
          $display("FAIL %s wrap: got %b want %b", e.name, wrap, e.wrap);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // reset held two cycles with up-count requested
    stepq(1, 1, UP, 0, 0, 0, 0, 0, "rst0");
    stepq(1, 1, UP, 0, 0, 0, 0, 1, "rst1");
    stepq(0, 1, UP, 0, 1, 0, 0, 1, "up1");
    stepq(0, 1, UP, 0, 2, 0, 0, 1, "up2");
    stepq(0, 1, UP, 0, 3, 0, 0, 1, "up3");
    for (int i = 4; i <= 9; i++)
      stepq(0, 1, UP, 0, 4'(i), 0, 0, 1, "upseq");
    stepq(0, 1, UP, 0, 0, 1, 1, 1, "upwrap");
    stepq(0, 1, UP, 0, 1, 0, 0, 1, "upwrap_clr");

    // 20 up cycles from q=1: values 2..9,0,1..9,0,1 -> two wraps
    @(posedge clk); #2;
    wraps_seen = 0;
    for (int i = 0; i < 20; i++) begin
      logic [3:0] xq;
      xq = 4'((i + 2) % 10);
      stepq(0, 1, UP, 0, xq, xq == 4'd0, xq == 4'd0, 1, "up20");
    end
    @(posedge clk); #2;
    checks++;
    if (wraps_seen != 2) begin
      errs++;
      $display("FAIL wrap_count: got %0d want 2", wraps_seen);
    end

    // down wrap
    stepq(0, 1, LD, 2, 2, 0, 0, 1, "ld2");
    stepq(0, 1, DN, 0, 1, 0, 0, 1, "dn1");
    stepq(0, 1, DN, 0, 0, 0, 0, 1, "dn0");
    stepq(0, 1, DN, 0, 9, 1, 1, 1, "dnwrap");
    stepq(0, 1, DN, 0, 8, 0, 0, 1, "dn8");

    // load and clamp
    stepq(0, 1, LD, 7, 7, 0, 0, 1, "ld7");
    stepq(0, 1, LD, 13, 9, 0, 0, 1, "ld13clamp");
    stepq(0, 1, LD, 15, 9, 0, 0, 1, "ld15clamp");

    // hold / enable
    stepq(0, 1, LD, 5, 5, 0, 0, 1, "ld5");
    for (int i = 0; i < 3; i++)
      stepq(0, 0, UP, 0, 5, 0, 0, 1, "en0");
    stepq(0, 1, HOLD, 0, 5, 0, 0, 1, "hold");

    // tc gated by enable at q=0
    stepq(0, 1, LD, 0, 0, 0, 0, 1, "ld0");
    stepq(0, 0, DN, 0, 0, 0, 0, 1, "dn_en0");
    stepq(0, 1, DN, 0, 9, 1, 1, 1, "dn_en1");
    // tc=0 in load mode even at q=9
    stepq(0, 1, LD, 9, 9, 0, 0, 1, "ld9_tc");

    // reset mid-count at terminal count: no wrap pulse
    stepq(1, 1, UP, 0, 0, 0, 1, 1, "rst_tc");
    stepq(0, 1, UP, 0, 1, 0, 0, 1, "post_rst");

    @(posedge clk); #2;
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
